// File: rtl/hood_key_power_ctrl.sv
// Range-hood key front end: synchronise and debounce six buttons, run the power FSM, emit gated command pulses.
// Build macro HOOD_AUTO_OFF_EN adds an idle timer that powers the hood off after IDLE_OFF_CYCLES without a key press.
module hood_key_power_ctrl #(
    parameter longint unsigned DEBOUNCE_CYCLES   = 64'd2_000_000,
    parameter longint unsigned LONG_PRESS_CYCLES = 64'd300_000_000,
    parameter longint unsigned IDLE_OFF_CYCLES   = 64'd5_000_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic power_btn,
    input  logic menu_btn,
    input  logic speed1_btn,
    input  logic speed2_btn,
    input  logic speed3_btn,
    input  logic clean_btn,
    output logic power_status,
    output logic menu,
    output logic speed1,
    output logic speed2,
    output logic speed3,
    output logic clean,
    output logic off_pending
);
    localparam int unsigned N_KEYS  = 6;
    localparam int unsigned K_POWER = 0;
    localparam longint unsigned MAX_AB  = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ? DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
    localparam longint unsigned MAX_CYC = (MAX_AB > IDLE_OFF_CYCLES) ? MAX_AB : IDLE_OFF_CYCLES;
    localparam int unsigned CNT_W = (MAX_CYC > 64'd1) ? $clog2(MAX_CYC) : 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [2:0] {
        S_OFF,
        S_ON_HELD,
        S_ON,
        S_ON_PRESS,
        S_OFF_HELD
    } state_t;

    logic [N_KEYS-1:0] raw_c;
    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] level_d;
    logic [N_KEYS-1:0] press_c;
    cnt_t              db_cnt [N_KEYS];

    state_t state;
    state_t state_nxt;
    cnt_t   hold_cnt;
    cnt_t   hold_cnt_nxt;
    logic   idle_expire_c;
    logic [4:0] cmd_c;

    assign raw_c = {clean_btn, speed3_btn, speed2_btn, speed1_btn, menu_btn, power_btn};

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_c;
            sync2 <= sync1;
        end
    end

    // Debounce: level follows sync2 only after DEBOUNCE_CYCLES consecutive differing cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < N_KEYS; i++) db_cnt[i] <= '0;
        end else begin
            level_d <= level;
            for (int i = 0; i < N_KEYS; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 64'd1)) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press_c = level & ~level_d;

    // Fixed priority among command keys; lower-priority simultaneous presses are dropped
    always_comb begin
        cmd_c = '0;
        if (press_c[1])      cmd_c[0] = 1'b1;
        else if (press_c[2]) cmd_c[1] = 1'b1;
        else if (press_c[3]) cmd_c[2] = 1'b1;
        else if (press_c[4]) cmd_c[3] = 1'b1;
        else if (press_c[5]) cmd_c[4] = 1'b1;
    end

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            S_OFF:      if (press_c[K_POWER]) state_nxt = S_ON_HELD;
            S_ON_HELD:  if (!level[K_POWER]) state_nxt = S_ON;
            S_ON: begin
                if (press_c[K_POWER]) begin
                    state_nxt    = S_ON_PRESS;
                    hold_cnt_nxt = '0;
                end
            end
            S_ON_PRESS: begin
                if (hold_cnt == CNT_W'(LONG_PRESS_CYCLES - 64'd1)) state_nxt = S_OFF_HELD;
                else if (!level[K_POWER]) state_nxt = S_ON;
                else hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
            S_OFF_HELD: if (!level[K_POWER]) state_nxt = S_OFF;
            default:    state_nxt = S_OFF;
        endcase
        if (idle_expire_c) state_nxt = S_OFF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_OFF;
            hold_cnt     <= '0;
            power_status <= 1'b0;
            off_pending  <= 1'b0;
            {clean, speed3, speed2, speed1, menu} <= 5'b0;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_cnt_nxt;
            power_status <= (state_nxt == S_ON_HELD) || (state_nxt == S_ON) || (state_nxt == S_ON_PRESS);
            off_pending  <= (state_nxt == S_ON_PRESS);
            // Gate on the pre-edge power level so the power-on cycle emits nothing
            {clean, speed3, speed2, speed1, menu} <= power_status ? cmd_c : 5'b0;
        end
    end

`ifdef HOOD_AUTO_OFF_EN
    cnt_t idle_cnt;
    logic powered_c;

    assign powered_c     = (state == S_ON_HELD) || (state == S_ON) || (state == S_ON_PRESS);
    assign idle_expire_c = powered_c && (state != S_ON_PRESS) && !(|press_c)
                           && (idle_cnt == CNT_W'(IDLE_OFF_CYCLES - 64'd1));

    // Idle timer: held while a long press is being timed, cleared by any key press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (!powered_c || (|press_c) || idle_expire_c) begin
            idle_cnt <= '0;
        end else if (state != S_ON_PRESS) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end
`else
    assign idle_expire_c = 1'b0;
`endif

endmodule

// File: tb/tb_hood_key_power_ctrl.sv
// Bench for hood_key_power_ctrl: directed scenarios plus random key traffic checked every cycle against a run-length model.
`timescale 1ns/1ps
module tb_hood_key_power_ctrl;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int IDLE = 50;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic power_btn = 1'b0, menu_btn = 1'b0, speed1_btn = 1'b0;
    logic speed2_btn = 1'b0, speed3_btn = 1'b0, clean_btn = 1'b0;
    logic power_status, menu, speed1, speed2, speed3, clean, off_pending;
    logic [6:0] dut_outs;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hood_key_power_ctrl #(
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONG),
        .IDLE_OFF_CYCLES   (IDLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .power_btn    (power_btn),
        .menu_btn     (menu_btn),
        .speed1_btn   (speed1_btn),
        .speed2_btn   (speed2_btn),
        .speed3_btn   (speed3_btn),
        .clean_btn    (clean_btn),
        .power_status (power_status),
        .menu         (menu),
        .speed1       (speed1),
        .speed2       (speed2),
        .speed3       (speed3),
        .clean        (clean),
        .off_pending  (off_pending)
    );

    assign dut_outs = {off_pending, power_status, clean, speed3, speed2, speed1, menu};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    // Reference model: keys debounce by run length of the 2-cycle-delayed raw value
    logic [5:0] hist[$];
    logic [5:0] m_level, m_level_d, last_seen;
    int         run[6];
    bit         m_powered, m_await, m_off_pending, live;
    int         m_hold;
    logic [4:0] m_cmd;
`ifdef HOOD_AUTO_OFF_EN
    int         m_idle;
`endif

    task automatic model_reset();
        hist.delete();
        m_level = '0; m_level_d = '0; last_seen = '0;
        for (int b = 0; b < 6; b++) run[b] = 0;
        m_powered = 0; m_await = 0; m_off_pending = 0; m_hold = -1; m_cmd = '0;
`ifdef HOOD_AUTO_OFF_EN
        m_idle = 0;
`endif
        live = 1;
    endtask

    task automatic model_step();
        logic [5:0] raw, seen, press, new_level;
        bit pwr_old, any_press, expire;
        int hold_old;
        raw = {clean_btn, speed3_btn, speed2_btn, speed1_btn, menu_btn, power_btn};
        hist.push_back(raw);
        if (hist.size() > 3) void'(hist.pop_front());
        seen = (hist.size() == 3) ? hist[0] : 6'b0;
        press = m_level & ~m_level_d;
        new_level = m_level;
        for (int b = 0; b < 6; b++) begin
            if (seen[b] == last_seen[b]) run[b]++;
            else run[b] = 1;
            if (seen[b] != m_level[b] && run[b] >= DEB) new_level[b] = seen[b];
        end
        last_seen = seen;
        pwr_old = m_powered;
        hold_old = m_hold;
        any_press = |press;
        m_cmd = '0;
        if (pwr_old)
            for (int k = 1; k < 6; k++)
                if (m_cmd == 5'b0 && press[k]) m_cmd[k-1] = 1'b1;
        expire = 0;
`ifdef HOOD_AUTO_OFF_EN
        expire = pwr_old && hold_old < 0 && !any_press && m_idle == IDLE - 1;
`endif
        if (!m_powered) begin
            if (!m_await) begin
                if (press[0]) begin m_powered = 1; m_await = 1; end
            end else if (!m_level[0]) m_await = 0;
        end else if (m_await) begin
            if (!m_level[0]) m_await = 0;
        end else if (m_hold < 0) begin
            if (press[0]) m_hold = 0;
        end else if (m_hold == LONG - 1) begin
            m_powered = 0; m_await = 1; m_hold = -1;
        end else if (!m_level[0]) m_hold = -1;
        else m_hold++;
        if (expire) begin m_powered = 0; m_await = 0; m_hold = -1; end
`ifdef HOOD_AUTO_OFF_EN
        if (!pwr_old || any_press || expire) m_idle = 0;
        else if (hold_old < 0) m_idle++;
`endif
        m_off_pending = (m_hold >= 0);
        m_level_d = m_level;
        m_level = new_level;
    endtask

    always @(posedge clk) begin
        if (!rst) model_reset();
        else if (live) model_step();
    end

    always @(negedge clk)
        if (rst && live)
            check("cycle", 32'(dut_outs), 32'({m_off_pending, m_powered, m_cmd}));

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_keys(input logic [5:0] v);
        {clean_btn, speed3_btn, speed2_btn, speed1_btn, menu_btn, power_btn} = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, c_menu, c_s1, c_s2, c_s3, c_clean, seen_pend;
        set_keys('0);
        tick(3);
        check("reset_outs", 32'(dut_outs), 32'd0);
        rst = 1'b1;
        tick(3);

        // Bouncing power button, then stable high
        for (int i = 0; i < 3; i++) begin
            power_btn = 1'b1; tick(2);
            power_btn = 1'b0; tick(2);
        end
        power_btn = 1'b1;
        lat = 0;
        while (!power_status && lat < 50) begin @(negedge clk); lat++; end
        check("power_on_latency", 32'(lat), 32'd7);
        tick(5);
        power_btn = 1'b0; tick(15);
        power_btn = 1'b1; tick(10);
        power_btn = 1'b0; tick(15);
        check("short_hold_stays_on", 32'(power_status), 32'd1);
        check("short_hold_pending_clear", 32'(off_pending), 32'd0);

        // Long press turns the hood off
        seen_pend = 0;
        power_btn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (off_pending) seen_pend = 1;
        end
        check("long_press_pending_seen", 32'(seen_pend), 32'd1);
        check("long_press_off", 32'(power_status), 32'd0);
        power_btn = 1'b0; tick(15);

        // Commands are gated while off
        c_s2 = 0;
        speed2_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin @(negedge clk); c_s2 += int'(speed2); end
        speed2_btn = 1'b0; tick(10);
        check("gated_speed2", 32'(c_s2), 32'd0);

        power_btn = 1'b1; tick(10);
        power_btn = 1'b0; tick(12);
        check("repower", 32'(power_status), 32'd1);

        // Held speed2: exactly one single-cycle pulse
        c_menu = 0; c_s1 = 0; c_s2 = 0; c_s3 = 0; c_clean = 0;
        speed2_btn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            c_menu += int'(menu); c_s1 += int'(speed1); c_s2 += int'(speed2);
            c_s3 += int'(speed3); c_clean += int'(clean);
        end
        speed2_btn = 1'b0; tick(10);
        check("speed2_one_pulse", 32'(c_s2), 32'd1);
        check("speed2_no_others", 32'(c_menu + c_s1 + c_s3 + c_clean), 32'd0);

        // Simultaneous menu and clean: menu wins
        c_menu = 0; c_clean = 0;
        menu_btn = 1'b1; clean_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            c_menu += int'(menu); c_clean += int'(clean);
        end
        menu_btn = 1'b0; clean_btn = 1'b0; tick(10);
        check("priority_menu", 32'(c_menu), 32'd1);
        check("priority_clean_dropped", 32'(c_clean), 32'd0);

        // Reset in the middle of a long press
        power_btn = 1'b1;
        lat = 0;
        while (!off_pending && lat < 30) begin @(negedge clk); lat++; end
        check("hold_started", 32'(off_pending), 32'd1);
        tick(12);
        #2 rst = 1'b0;
        #1 check("reset_mid_hold", 32'(dut_outs), 32'd0);
        tick(2);
        rst = 1'b1;
        lat = 0;
        while (!power_status && lat < 50) begin @(negedge clk); lat++; end
        check("held_after_reset_latency", 32'(lat), 32'd7);
        power_btn = 1'b0; tick(15);

        // Idle interval, restarted by a speed1 press
        speed1_btn = 1'b1; tick(6);
        speed1_btn = 1'b0; tick(40);
        check("idle_restart_on", 32'(power_status), 32'd1);
        tick(30);
`ifdef HOOD_AUTO_OFF_EN
        check("idle_auto_off", 32'(power_status), 32'd0);
`else
        check("no_auto_off", 32'(power_status), 32'd1);
`endif

        // Random key traffic against the model
        for (int s = 0; s < 150; s++) begin
            logic [5:0] v;
            v = 6'($urandom) & 6'b111110;
            if ($urandom_range(0, 3) == 0) v[0] = 1'b1;
            if ($urandom_range(0, 2) == 0) v = '0;
            set_keys(v);
            tick(int'($urandom_range(1, 12)) * (($urandom_range(0, 4) == 0) ? 4 : 1));
        end
        set_keys('0);
        tick(20);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hood_key_power_ctrl.md
Name: hood_key_power_ctrl

Overview:
- Front-end input conditioner for the range-hood controller. Sits directly upstream of the hood mode state machine.
- Converts six raw, bouncing, asynchronous push-buttons into the signals that machine consumes:
  - `power_status`, a level, driven by a power-button FSM (short press turns on, long press turns off);
  - one-cycle, mutually exclusive command pulses `menu`, `speed1`, `speed2`, `speed3` and `clean`, emitted only while powered.

Parameters:
- DEBOUNCE_CYCLES, 2_000_000: consecutive stable cycles required before the debounced level changes (20 ms at 100 MHz).
- LONG_PRESS_CYCLES, 300_000_000: power-button hold time that turns the hood off (3 s).
- IDLE_OFF_CYCLES, 500_000_000_0: no-key interval before auto power-off. Used only with HOOD_AUTO_OFF_EN.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, asynchronous, active-low
- power_btn  in  1  raw power button, active-high, asynchronous
- menu_btn  in  1  raw menu button
- speed1_btn  in  1  raw speed-1 button
- speed2_btn  in  1  raw speed-2 button
- speed3_btn  in  1  raw speed-3 button
- clean_btn  in  1  raw self-clean button
- power_status  out  1  hood powered (level)
- menu  out  1  one-cycle command pulse
- speed1  out  1  one-cycle command pulse
- speed2  out  1  one-cycle command pulse
- speed3  out  1  one-cycle command pulse
- clean  out  1  one-cycle command pulse
- off_pending  out  1  high while a long-press power-off is being timed

Behaviour:
- Reset (`rst`=0, asynchronous):
  - All outputs 0.
  - Synchronizers, debounced levels and counters 0.
  - Power FSM enters OFF.
- Input path, per button:
  - 2-flop synchronizer, then debouncer.
  - Debouncer: a counter runs while the synchronized value differs from the debounced level and clears on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the new value and the counter clears.
  - Counter width is `$clog2` of the largest cycle parameter; there is no wrap.
- Edge detect:
  - A press is a debounced 0->1 transition.
  - Latency from a stable raw change to the output pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
- Command pulses:
  - Registered, high for exactly 1 cycle per press.
  - Suppressed while `power_status`=0 and in the cycle `power_status` rises.
  - Simultaneous presses in one cycle resolve by fixed priority menu > speed1 > speed2 > speed3 > clean; lower-priority presses are dropped, not queued.
  - A held key produces no repeats.
- Power FSM states:
  - OFF (`power_status`=0): power press -> ON_HELD.
  - ON_HELD (`power_status`=1): waiting for release of the press that turned the hood on. Debounced release -> ON. The held time is never counted.
  - ON (`power_status`=1): power press -> ON_PRESS with the hold counter cleared.
  - ON_PRESS (`power_status`=1, `off_pending`=1): counts once per cycle.
    - Release before LONG_PRESS_CYCLES -> ON, no other effect.
    - Counter reaches LONG_PRESS_CYCLES-1 -> OFF_HELD.
  - OFF_HELD (`power_status`=0): waiting for release. Release -> OFF. No re-arm until released.
- `power_status` is registered. It drops the cycle after the transition into OFF_HELD.
- Presses of other keys during ON_PRESS still generate pulses.
- Reset mid-hold: immediately OFF. A button still held after reset releases needs no release first, because debounced levels restart at 0 and the held button reads as a new press.

Optional Feature:
- Macro: HOOD_AUTO_OFF_EN.
- Defined:
  - An idle counter runs while `power_status`=1.
  - It clears on any debounced press (any key) and on entry to ON_HELD.
  - Reaching IDLE_OFF_CYCLES-1 forces the FSM to OFF, drops `power_status` the next cycle, and clears the counter.
  - In ON_PRESS the long press takes precedence; the idle counter is held.
- Undefined: no idle counter is built; the hood turns off only by long press or reset.

Test Plan (all scenarios use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, IDLE_OFF_CYCLES=50):
- Bounce: `power_btn` toggles every 2 cycles for 10 cycles, then holds 1 -> `power_status` rises exactly 2+4+1 cycles after the final stable edge. Releasing and holding 1 again for 10 cycles does not drop it.
- Long press: while ON, hold `power_btn` 30 cycles -> `off_pending` high, `power_status` falls once the counted hold reaches 20. Hold 10 cycles instead -> `power_status` stays 1, `off_pending` returns to 0.
- Commands gated: while OFF, press `speed2` -> no pulse. While ON, press `speed2` -> `speed2`=1 for exactly 1 cycle, others 0; holding 40 cycles gives no repeat.
- Priority: while ON, `menu_btn` and `clean_btn` rise in the same cycle -> only `menu` pulses.
- Reset mid-operation: assert `rst`=0 during ON_PRESS at hold count 12 -> all outputs 0 immediately. After deassert, still-held `power_btn` powers on after 2+4+1 cycles.
- HOOD_AUTO_OFF_EN: power on, release, no keys for 50 cycles -> `power_status`=0. A `speed1` press at cycle 40 restarts the count.
